// File: rtl/imem_loader.sv
// Boot-time program loader: receives a length/data/checksum byte frame, writes
// little-endian 32-bit words into instruction memory and releases the CPU reset on success.
module imem_loader #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] word_len;
    logic [15:0] word_cnt;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic [7:0]  chk_acc;
    logic        fire;
    logic [15:0] len_full;

    assign fire     = byte_valid && byte_ready;
    assign len_full = {byte_data, len_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            word_len   <= '0;
            word_cnt   <= '0;
            lane       <= '0;
            word_buf   <= '0;
            chk_acc    <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN0;
                        byte_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        chk_acc    <= '0;
                        word_cnt   <= '0;
                        lane       <= '0;
                        waddr      <= '0;
                    end
                end
                S_LEN0: begin
                    if (fire) begin
                        len_lo <= byte_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (fire) begin
                        word_len <= len_full;
                        if (len_full > DEPTH16) begin
                            state      <= S_ERR;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        chk_acc <= chk_acc ^ byte_data;
                        if (lane == 2'd3) begin
                            // Lanes 0..2 sit in word_buf LSB-first; the 4th byte completes the word.
                            we       <= 1'b1;
                            waddr    <= {14'd0, word_cnt, 2'b00};
                            wdata    <= {byte_data, word_buf};
                            word_cnt <= word_cnt + 16'd1;
                            lane     <= '0;
                            if (word_cnt == word_len - 16'd1) begin
                                state <= S_CHK;
                            end
                        end else begin
                            word_buf <= {byte_data, word_buf[23:8]};
                            lane     <= lane + 2'd1;
                        end
                    end
                end
                S_CHK: begin
                    if (fire) begin
                        byte_ready <= 1'b0;
                        if (byte_data == chk_acc) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_rst    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: per-scenario tasks with inline
// comparisons against hand-computed frame results.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(.DEPTH_WORDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captures every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa.push_back(waddr);
            wd.push_back(wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waitc;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'h55;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waitc = 0;
        while (byte_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout byte=%02h byte_ready=%b required=1", b, byte_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (byte_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL start_accept ready/done/error/cpu_rst=%b%b%b%b required=1001",
                     byte_ready, done, error, cpu_rst);
        end
    endtask

    task automatic send_basic(input logic [7:0] chk, input logic stall);
        logic [7:0] fr[11];
        int gaps[8];
        fr   = '{8'h02, 8'h00, 8'h0B, 8'h80, 8'hA0, 8'hE3, 8'hFE, 8'hFF, 8'hFF, 8'hEA, 8'h00};
        gaps = '{0, 2, 1, 0, 3, 1, 2, 0};
        fr[10] = chk;
        for (int i = 0; i < 11; i++) begin
            send_byte(fr[i], stall ? gaps[i % 8] : 0);
        end
        end_frame();
    endtask

    task automatic check_basic_writes(input string tag);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea = '{32'h0, 32'h4};
        ed = '{32'hE3A0800B, 32'hEAFFFFFE};
        checks++;
        if (wa.size() != 2) begin
            failures++;
            $display("FAIL %s_write_count got=%0d required=2", tag, wa.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL %s_write%0d got=(%h,%h) required=(%h,%h)",
                             tag, i, wa[i], wd[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || we !== 1'b0 || waddr !== 32'h0 || wdata !== 32'h0 ||
            cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_values ready=%b we=%b waddr=%h wdata=%h cpu_rst=%b done=%b error=%b required=0 0 0 0 1 0 0",
                     byte_ready, we, waddr, wdata, cpu_rst, done, error);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset ready=%b cpu_rst=%b required=0 1", byte_ready, cpu_rst);
        end
    endtask

    task automatic test_basic();
        wa.delete();
        wd.delete();
        do_start();
        send_basic(8'hDC, 1'b0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_done done=%b error=%b cpu_rst=%b ready=%b required=1 0 0 0",
                     done, error, cpu_rst, byte_ready);
        end
        check_basic_writes("basic");
    endtask

    task automatic test_bad_checksum();
        wa.delete();
        wd.delete();
        do_start();
        send_basic(8'hDD, 1'b0);
        checks++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL badchk_state done=%b error=%b cpu_rst=%b ready=%b required=0 1 1 0",
                     done, error, cpu_rst, byte_ready);
        end
        check_basic_writes("badchk");
    endtask

    task automatic test_stall();
        wa.delete();
        wd.delete();
        do_start();
        send_basic(8'hDC, 1'b1);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL stall_done done=%b error=%b cpu_rst=%b required=1 0 0", done, error, cpu_rst);
        end
        check_basic_writes("stall");
    endtask

    task automatic test_len_limits();
        wa.delete();
        wd.delete();
        do_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        end_frame();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL len_overflow error=%b done=%b ready=%b cpu_rst=%b required=1 0 0 1",
                     error, done, byte_ready, cpu_rst);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 0) begin
            failures++;
            $display("FAIL len_overflow_writes got=%0d required=0", wa.size());
        end
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        end_frame();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL len_zero_done done=%b error=%b cpu_rst=%b required=1 0 0", done, error, cpu_rst);
        end
        checks++;
        if (wa.size() != 0) begin
            failures++;
            $display("FAIL len_zero_writes got=%0d required=0", wa.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] fr[6];
        fr = '{8'h02, 8'h00, 8'h0B, 8'h80, 8'hA0, 8'hE3};
        do_start();
        for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if (byte_ready !== 1'b0 || we !== 1'b0 || waddr !== 32'h0 || wdata !== 32'h0 ||
            cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL midreset_values ready=%b we=%b waddr=%h wdata=%h cpu_rst=%b done=%b error=%b required=0 0 0 0 1 0 0",
                     byte_ready, we, waddr, wdata, cpu_rst, done, error);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wa.delete();
        wd.delete();
        do_start();
        send_basic(8'hDC, 1'b0);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL midreset_reload done=%b cpu_rst=%b required=1 0", done, cpu_rst);
        end
        check_basic_writes("midreset");
    endtask

    task automatic test_restart();
        logic [7:0] fr[7];
        fr = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        wa.delete();
        wd.delete();
        do_start();
        send_byte(fr[0], 0);
        send_byte(fr[1], 0);
        send_byte(fr[2], 0);
        #1;
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_inflight cpu_rst=%b done=%b required=1 0", cpu_rst, done);
        end
        for (int i = 3; i < 7; i++) send_byte(fr[i], 0);
        end_frame();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL restart_done done=%b cpu_rst=%b error=%b required=1 0 0", done, cpu_rst, error);
        end
        checks++;
        if (wa.size() != 1) begin
            failures++;
            $display("FAIL restart_write_count got=%0d required=1", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h00000001) begin
                failures++;
                $display("FAIL restart_write got=(%h,%h) required=(00000000,00000001)", wa[0], wd[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_stall();
        test_len_limits();
        test_mid_reset();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
